// File: rtl/defines_pkg.sv
// Shared types and width constants for the dnn sequencer and datapath.
package defines_pkg;

  localparam int X_W    = 7;   // signed input activation width
  localparam int RELU_W = 13;  // ReLU result width returned from dnn
  localparam int AGGR_W = 15;  // aggregated operand width sent to dnn

  // Default sequential encoding keeps IDLE at 0 and L1_Y4Y5_MUL at 1. The
  // datapath's fall-through weight selection therefore resolves to the
  // y4/y5 weights.
  typedef enum logic [2:0] {
    IDLE,
    L1_Y4Y5_MUL,
    LAYER1_y6y7_MUL,
    LAYER1_FINAL_ADD,
    OUTPUT_MUL,
    OUTPUT_ADD
  } dnn_state_t;

endpackage

// File: rtl/dnn_ctrl.sv
// dnn_ctrl: five-stage inference sequencer, input operand buffer and
// saturating dropped-request counter for the dnn datapath.
module dnn_ctrl
  import defines_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_ready,
  input  logic signed [X_W-1:0]    x0_in,
  input  logic signed [X_W-1:0]    x1_in,
  input  logic signed [X_W-1:0]    x2_in,
  input  logic signed [X_W-1:0]    x3_in,
  input  logic        [RELU_W-1:0] y4_relu_p4,
  input  logic        [RELU_W-1:0] y5_relu_p4,
  input  logic        [RELU_W-1:0] y6_relu_p4,
  input  logic        [RELU_W-1:0] y7_relu_p4,
  output logic                     in_accept,
  output logic                     busy,
  output logic signed [X_W-1:0]    x0,
  output logic signed [X_W-1:0]    x1,
  output logic signed [X_W-1:0]    x2,
  output logic signed [X_W-1:0]    x3,
  output dnn_state_t               dnn_state,
  output logic        [AGGR_W-1:0] y4_aggr_p4,
  output logic        [AGGR_W-1:0] y5_aggr_p4,
  output logic        [AGGR_W-1:0] y6_aggr_p4,
  output logic        [AGGR_W-1:0] y7_aggr_p4,
  output logic                     out_comp_ready_p5,
  output logic        [DROP_W-1:0] drop_cnt
);

  dnn_state_t                r_state;
  dnn_state_t                w_next_state;
  logic                      w_accept;
  logic                      w_drop;
  logic                      w_out_mul;
  logic signed [X_W-1:0]     r_x0, r_x1, r_x2, r_x3;
  logic        [DROP_W-1:0]  r_drop_cnt;

  // Acceptance, drop detection and next-state selection.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_next_state = r_state;

    // A vector is taken only when idle or in the last stage of the previous
    // inference; nothing is taken while reset is applied.
    w_accept = ~rst & in_ready & ((r_state == IDLE) | (r_state == OUTPUT_ADD));
    w_drop   = ~rst & in_ready & ~w_accept;

    case (r_state)
      IDLE:             w_next_state = w_accept ? L1_Y4Y5_MUL : IDLE;
      L1_Y4Y5_MUL:      w_next_state = LAYER1_y6y7_MUL;
      LAYER1_y6y7_MUL:  w_next_state = LAYER1_FINAL_ADD;
      LAYER1_FINAL_ADD: w_next_state = OUTPUT_MUL;
      OUTPUT_MUL:       w_next_state = OUTPUT_ADD;
      OUTPUT_ADD:       w_next_state = w_accept ? L1_Y4Y5_MUL : IDLE;
      default:          w_next_state = IDLE;
    endcase
  end

  // Schedule state register; reset aborts any inference in flight.
  // NOTE: sequential state is updated with <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Operand buffer: captures the activations on accept and holds them until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_x3 <= '0;
    end else if (w_accept) begin
      r_x0 <= x0_in;
      r_x1 <= x1_in;
      r_x2 <= x2_in;
      r_x3 <= x3_in;
    end
  end

  // Saturating count of requests refused while an inference is in flight.
  always_ff @(posedge clk) begin
    if (rst)                                  r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1))    r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  // ReLU results are non-negative, so a zero-extending cast keeps their value.
  assign w_out_mul  = (r_state == OUTPUT_MUL);
  assign y4_aggr_p4 = w_out_mul ? AGGR_W'(y4_relu_p4) : '0;
  assign y5_aggr_p4 = w_out_mul ? AGGR_W'(y5_relu_p4) : '0;
  assign y6_aggr_p4 = w_out_mul ? AGGR_W'(y6_relu_p4) : '0;
  assign y7_aggr_p4 = w_out_mul ? AGGR_W'(y7_relu_p4) : '0;

  assign in_accept         = w_accept;
  assign busy              = (r_state != IDLE);
  assign dnn_state         = r_state;
  assign out_comp_ready_p5 = (r_state == OUTPUT_ADD);
  assign drop_cnt          = r_drop_cnt;
  assign x0                = r_x0;
  assign x1                = r_x1;
  assign x2                = r_x2;
  assign x3                = r_x3;

endmodule
